// File: rtl/keypad_scanner.sv
// keypad_scanner: scans, synchronises and debounces a 4x4 calculator keypad and decodes presses
module keypad_scanner #(
    parameter int SCAN_DIV = 16,
    parameter int DEBOUNCE = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input,
    output logic       clear_input
);
    localparam int CMAX = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_FIRE, ST_HELD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_m_q, row_s_q;
    logic [3:0]    col_q, col_d, cap_q, cap_d;
    logic [CW-1:0] div_q, div_d, deb_q, deb_d, rel_q, rel_d;
    logic [3:0]    key_q, key_d;
    logic [2:0]    op_q, op_d;
    logic          eq_q, eq_d, rd_q, rd_d, clr_q, clr_d;
    logic [1:0]    r_idx, c_idx;
    logic [3:0]    col_next, digit;
    logic [CW-1:0] deb_inc, rel_inc;
    logic          row_one_hot, is_digit, is_op, is_eq, is_clr;

    assign row_one_hot = (row_s_q != 4'd0) && ((row_s_q & (row_s_q - 4'd1)) == 4'd0);
    assign col_next    = {col_q[2:0], col_q[3]};
    assign r_idx       = cap_q[3] ? 2'd3 : cap_q[2] ? 2'd2 : cap_q[1] ? 2'd1 : 2'd0;
    assign c_idx       = col_q[3] ? 2'd3 : col_q[2] ? 2'd2 : col_q[1] ? 2'd1 : 2'd0;
    assign is_op       = (c_idx == 2'd3) && (r_idx != 2'd3);
    assign is_eq       = (r_idx == 2'd3) && (c_idx == 2'd2);
    assign is_clr      = (r_idx == 2'd3) && (c_idx == 2'd0);
    assign is_digit    = (c_idx != 2'd3) && !is_eq && !is_clr;
    assign digit       = (r_idx == 2'd3) ? 4'd0 : {2'b00, r_idx} * 4'd3 + {2'b00, c_idx} + 4'd1;
    assign deb_inc     = deb_q + 1'b1;
    assign rel_inc     = rel_q + 1'b1;

    // two-flop synchroniser for the asynchronous row lines
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            row_m_q <= 4'd0;
            row_s_q <= 4'd0;
        end else begin
            row_m_q <= row_in;
            row_s_q <= row_m_q;
        end
    end

    // scan / debounce / fire / held sequencing and output event decode
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cap_d   = cap_q;
        div_d   = div_q;
        deb_d   = deb_q;
        rel_d   = rel_q;
        key_d   = key_q;
        op_d    = op_q;
        eq_d    = eq_q;
        rd_d    = 1'b0;
        clr_d   = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (row_one_hot) begin
                        cap_d   = row_s_q;
                        deb_d   = CW'(1);
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (row_s_q == cap_q) begin
                    deb_d = deb_inc;
                    if (deb_inc == DEB_MAX) begin
                        state_d = ST_FIRE;
                        if (is_digit) begin
                            key_d = digit;
                            rd_d  = 1'b1;
                            eq_d  = 1'b0;
                        end
                        if (is_op) op_d = 3'b001 << r_idx;
                        if (is_eq) eq_d = 1'b1;
                        if (is_clr) begin
                            clr_d = 1'b1;
                            op_d  = 3'b000;
                            eq_d  = 1'b0;
                        end
                    end
                end else begin
                    state_d = ST_SCAN;
                    col_d   = col_next;
                    div_d   = '0;
                end
            end
            ST_FIRE: begin
                state_d = ST_HELD;
                rel_d   = '0;
            end
            ST_HELD: begin
                if (row_s_q == 4'd0) begin
                    rel_d = rel_inc;
                    if (rel_inc == DEB_MAX) begin
                        state_d = ST_SCAN;
                        col_d   = col_next;
                        div_d   = '0;
                        rel_d   = '0;
                    end
                end else begin
                    rel_d = '0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    // state, counters and output registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_SCAN;
            col_q   <= 4'b0001;
            cap_q   <= 4'd0;
            div_q   <= '0;
            deb_q   <= '0;
            rel_q   <= '0;
            key_q   <= 4'd0;
            op_q    <= 3'b000;
            eq_q    <= 1'b0;
            rd_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cap_q   <= cap_d;
            div_q   <= div_d;
            deb_q   <= deb_d;
            rel_q   <= rel_d;
            key_q   <= key_d;
            op_q    <= op_d;
            eq_q    <= eq_d;
            rd_q    <= rd_d;
            clr_q   <= clr_d;
        end
    end

    assign col_out        = col_q;
    assign keypad_input   = key_q;
    assign read_input     = rd_q;
    assign operator_input = op_q;
    assign equal_input    = eq_q;
    assign clear_input    = clr_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench driving a modelled key matrix into keypad_scanner
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] row_in, col_out, keypad_input;
    logic       read_input, equal_input, clear_input;
    logic [2:0] operator_input;

    logic [3:0][3:0] pm = '0;
    logic [9:0]      sbq[$];
    int              n_tests = 0, n_fail = 0, ev_cnt = 0;
    logic [2:0]      prev_op = 3'b000;
    logic            prev_eq = 1'b0;
    logic [3:0]      key_m = 4'd0;
    logic [2:0]      op_m = 3'b000;
    logic            eq_m = 1'b0;
    byte             km [4][4] = '{'{"1", "2", "3", "+"},
                                   '{"4", "5", "6", "-"},
                                   '{"7", "8", "9", "*"},
                                   '{"C", "0", "=", "u"}};

    always #5 clk = ~clk;

    assign row_in = {|(pm[3] & col_out), |(pm[2] & col_out), |(pm[1] & col_out), |(pm[0] & col_out)};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk),
        .nRST(nRST),
        .row_in(row_in),
        .col_out(col_out),
        .keypad_input(keypad_input),
        .read_input(read_input),
        .operator_input(operator_input),
        .equal_input(equal_input),
        .clear_input(clear_input)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {read_input, clear_input, keypad_input, operator_input, equal_input};
    endfunction

    task automatic expect_key(input byte ch);
        logic rd, cl;
        rd = 1'b0;
        cl = 1'b0;
        case (ch)
            "+": op_m = 3'b001;
            "-": op_m = 3'b010;
            "*": op_m = 3'b100;
            "=": eq_m = 1'b1;
            "C": begin
                cl   = 1'b1;
                op_m = 3'b000;
                eq_m = 1'b0;
            end
            default: begin
                rd    = 1'b1;
                key_m = 4'(ch - 8'd48);
                eq_m  = 1'b0;
            end
        endcase
        sbq.push_back({rd, cl, key_m, op_m, eq_m});
    endtask

    task automatic set_key(input byte ch, input logic v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (km[r][c] == ch) pm[r][c] = v;
    endtask

    task automatic wait_event(input string tag, input int n0);
        for (int i = 0; i < 100 && ev_cnt == n0; i++) @(negedge clk);
        chk(tag, 16'(ev_cnt != n0), 16'd1);
    endtask

    task automatic press(input byte ch);
        int n0;
        n0 = ev_cnt;
        expect_key(ch);
        set_key(ch, 1'b1);
        wait_event($sformatf("evt_%c", ch), n0);
        set_key(ch, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (nRST && (read_input || clear_input || operator_input != prev_op || equal_input != prev_eq)) begin
            ev_cnt++;
            chk("evt_expected", 16'(sbq.size() != 0), 16'd1);
            if (sbq.size() != 0) chk("evt_value", 16'(outs()), 16'(sbq.pop_front()));
        end
        prev_op = operator_input;
        prev_eq = equal_input;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    n0;
        logic  seen;
        string s;
        repeat (3) @(negedge clk);
        chk("rst_col", 16'(col_out), 16'h1);
        chk("rst_outs", 16'(outs()), 16'h0);
        nRST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("idle_col", 16'(col_out), 16'(4'b0001 << ((i / 4) % 4)));
            @(negedge clk);
        end
        chk("idle_outs", 16'(outs()), 16'h0);

        n0 = ev_cnt;
        expect_key("7");
        set_key("7", 1'b1);
        wait_event("evt_7_first", n0);
        set_key("7", 1'b0);
        repeat (2) @(negedge clk);
        set_key("7", 1'b1);
        n0 = ev_cnt;
        repeat (20) @(negedge clk);
        chk("no_reaccept", 16'(ev_cnt), 16'(n0));
        set_key("7", 1'b0);
        repeat (12) @(negedge clk);
        press("7");

        n0 = ev_cnt;
        for (int i = 0; i < 48; i++) begin
            set_key("+", 1'(i % 3 != 2));
            @(negedge clk);
        end
        set_key("+", 1'b0);
        repeat (12) @(negedge clk);
        chk("bounce_no_evt", 16'(ev_cnt), 16'(n0));
        press("+");
        chk("op_held", 16'(operator_input), 16'h1);

        s = "12*3=4";
        for (int i = 0; i < s.len(); i++) press(s[i]);

        n0 = ev_cnt;
        seen = 1'b0;
        pm[0][0] = 1'b1;
        pm[1][0] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (col_out == 4'b1000) seen = 1'b1;
            @(negedge clk);
        end
        pm = '0;
        repeat (12) @(negedge clk);
        chk("multi_no_evt", 16'(ev_cnt), 16'(n0));
        chk("multi_col_adv", 16'(seen), 16'h1);
        press("-");
        press("C");

        n0 = ev_cnt;
        expect_key("5");
        set_key("5", 1'b1);
        wait_event("evt_5_pre", n0);
        repeat (2) @(negedge clk);
        nRST = 1'b0;
        #1;
        chk("rst_held_col", 16'(col_out), 16'h1);
        chk("rst_held_outs", 16'(outs()), 16'h0);
        key_m = 4'd0;
        op_m  = 3'b000;
        eq_m  = 1'b0;
        set_key("5", 1'b0);
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        n0 = ev_cnt;
        repeat (40) @(negedge clk);
        chk("rst_no_spurious", 16'(ev_cnt), 16'(n0));
        press("5");

        chk("sb_empty", 16'(sbq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
